// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory loader.
//   IMEM_ADDR_W    : word-address width of the instruction memory (1024 words)
//   HDR_LEN        : number of frame header bytes (16-bit big-endian word count)
//   loader_state_t : loader FSM state encoding
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CSUM state.
package imem_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int HDR_LEN     = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM   = 3'd4,
`endif
        ST_FIN    = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles big-endian 32-bit words from a byte stream.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart at lane 0 (beginning of a new load)
//   byte_en    : a payload byte is accepted this cycle
//   byte_in    : payload byte
//   word       : assembled word, valid while word_done is high
//   word_done  : high in the cycle the 4th byte of a word is accepted
module imem_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  lane;
    logic [23:0] shreg;

    // Lane counter and the first three bytes of the current word; the
    // fourth byte is combined directly so the word is ready on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane  <= 2'd0;
            shreg <= 24'd0;
        end else if (clear) begin
            lane  <= 2'd0;
        end else if (byte_en) begin
            lane  <= lane + 2'd1;
            shreg <= {shreg[15:0], byte_in};
        end
    end

    assign word_done = byte_en && (lane == 2'd3);
    assign word      = {shreg, byte_in};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a framed byte stream into the instruction memory.
// Frame: LEN_HI, LEN_LO (word count N), 4*N payload bytes MSB first,
// plus one XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : begin a load (ignored while busy)
//   byte_valid/byte_data  : input byte stream
//   byte_ready            : loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data : instruction memory write port
//   busy, cpu_hold        : load in progress / hold the CPU in reset
//   done, error           : sticky status of the last load
//   word_count            : words written in the current or last load
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [16:0] MEM_DEPTH = 17'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t PAYLOAD_END = ST_CSUM;
`else
    localparam loader_state_t PAYLOAD_END = ST_FIN;
`endif

    loader_state_t state_q, state_d;

    logic [7:0]  len_hi_q;
    logic [15:0] total_words_q;
    logic [15:0] len_n;
    logic        accept;
    logic        start_ok;
    logic        last_word;
    logic        word_done;
    logic [31:0] word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign byte_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                        (state_q == ST_CSUM) ||
`endif
                        (state_q == ST_DATA);
    assign busy       = byte_ready;
    assign cpu_hold   = busy;
    assign done       = (state_q == ST_FIN);
    assign error      = (state_q == ST_ERR);

    assign accept     = byte_valid && byte_ready;
    assign start_ok   = start && !busy;
    assign len_n      = {len_hi_q, byte_data};
    assign last_word  = ((16'(word_count) + 16'd1) == total_words_q);

    imem_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .byte_en   (accept && (state_q == ST_DATA)),
        .byte_in   (byte_data),
        .word      (word),
        .word_done (word_done)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; lengths above the memory depth abort before any write
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FIN, ST_ERR: if (start) state_d = ST_LEN_HI;
            ST_LEN_HI: if (accept) state_d = ST_LEN_LO;
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_n == 16'd0)                    state_d = PAYLOAD_END;
                    else if ({1'b0, len_n} > MEM_DEPTH)    state_d = ST_ERR;
                    else                                   state_d = ST_DATA;
                end
            end
            ST_DATA: if (word_done && last_word) state_d = PAYLOAD_END;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: if (accept) state_d = (byte_data == csum_q) ? ST_FIN : ST_ERR;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Header capture, write port and word counter; wr_addr follows the
    // count of words already written, so the first word lands at address 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi_q      <= 8'd0;
            total_words_q <= 16'd0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= 32'd0;
            word_count    <= '0;
        end else begin
            wr_en <= word_done;
            if (start_ok) begin
                word_count <= '0;
            end
            if (accept && (state_q == ST_LEN_HI)) len_hi_q <= byte_data;
            if (accept && (state_q == ST_LEN_LO)) total_words_q <= len_n;
            if (word_done) begin
                wr_addr    <= word_count[ADDR_W-1:0];
                wr_data    <= word;
                word_count <= word_count + 1'b1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over payload bytes only
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              csum_q <= 8'd0;
        else if (start_ok)                      csum_q <= 8'd0;
        else if (accept && (state_q == ST_DATA)) csum_q <= csum_q ^ byte_data;
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [10:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [9:0]  log_addr [0:7];
    logic [31:0] log_data [0:7];
    int n_writes = 0;
    int wr_pairs = 0;
    int ready_drops = 0;
    logic prev_wr_en = 1'b0;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en) begin
            if (n_writes < 8) begin
                log_addr[n_writes] = wr_addr;
                log_data[n_writes] = wr_data;
            end
            n_writes = n_writes + 1;
            if (prev_wr_en) wr_pairs = wr_pairs + 1;
        end
        prev_wr_en = wr_en;
    end

    // Called at a negedge; returns at the negedge after the byte is accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        byte_valid = 1'b1;
        byte_data  = b;
        k = 0;
        while (!byte_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) begin
            errors++;
            $display("[TB] FAIL ready_timeout byte=%02h got byte_ready=0 want 1", b);
        end
        @(posedge clk);
        @(negedge clk);
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) begin
                if (!byte_ready) ready_drops++;
                @(negedge clk);
            end
        end
    endtask

    task automatic send_csum(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(b, 0);
`else
        b = b;
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({byte_ready, wr_en, busy, cpu_hold, done, error} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b want 000000", {byte_ready, wr_en, busy, cpu_hold, done, error});
        end
        checks++;
        if (wr_addr !== 10'd0 || wr_data !== 32'd0 || word_count !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_data got addr=%0d data=%h cnt=%0d want 0 0 0", wr_addr, wr_data, word_count);
        end
    endtask

    task automatic test_basic(input int gap);
        logic [7:0] pl [0:7];
        pl = '{8'h24, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        n_writes = 0;
        ready_drops = 0;
        pulse_start();
        checks++;
        if (byte_ready !== 1'b1 || busy !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_state gap=%0d got rdy=%b busy=%b hold=%b done=%b want 1 1 1 0", gap, byte_ready, busy, cpu_hold, done);
        end
        send_byte(8'h00, gap);
        send_byte(8'h02, gap);
        for (int i = 0; i < 8; i++) send_byte(pl[i], (i == 7) ? 0 : gap);
        send_csum(8'h8D);
        byte_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done gap=%0d got done=%b busy=%b hold=%b err=%b want 1 0 0 0", gap, done, busy, cpu_hold, error);
        end
        @(negedge clk);
        checks++;
        if (n_writes !== 2 || word_count !== 11'd2) begin
            errors++;
            $display("[TB] FAIL basic_count gap=%0d got writes=%0d cnt=%0d want 2 2", gap, n_writes, word_count);
        end
        checks++;
        if (log_addr[0] !== 10'd0 || log_data[0] !== 32'h24080005) begin
            errors++;
            $display("[TB] FAIL basic_word0 gap=%0d got %0d:%h want 0:24080005", gap, log_addr[0], log_data[0]);
        end
        checks++;
        if (log_addr[1] !== 10'd1 || log_data[1] !== 32'hAC080000) begin
            errors++;
            $display("[TB] FAIL basic_word1 gap=%0d got %0d:%h want 1:ac080000", gap, log_addr[1], log_data[1]);
        end
        checks++;
        if (ready_drops !== 0) begin
            errors++;
            $display("[TB] FAIL ready_drop gap=%0d got %0d want 0", gap, ready_drops);
        end
    endtask

    task automatic test_zero_length();
        n_writes = 0;
        pulse_start();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_clear got done=%b want 0", done);
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_csum(8'h00);
        byte_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_done got done=%b busy=%b want 1 0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (n_writes !== 0 || word_count !== 11'd0) begin
            errors++;
            $display("[TB] FAIL zero_writes got writes=%0d cnt=%0d want 0 0", n_writes, word_count);
        end
    endtask

    task automatic test_oversize();
        n_writes = 0;
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oversize_err got err=%b done=%b rdy=%b busy=%b want 1 0 0 0", error, done, byte_ready, busy);
        end
        byte_data = 8'h55;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if (n_writes !== 0 || error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oversize_hold got writes=%0d err=%b want 0 1", n_writes, error);
        end
        pulse_start();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL recover_clear got err=%b busy=%b want 0 1", error, busy);
        end
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        send_csum(8'h22);
        byte_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || n_writes !== 1 || log_addr[0] !== 10'd0 || log_data[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL recover_write got done=%b writes=%0d %0d:%h want 1 1 0:deadbeef", done, n_writes, log_addr[0], log_data[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        n_writes = 0;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'hCA, 0); send_byte(8'hFE, 0); send_byte(8'hBA, 0); send_byte(8'hBE, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if ({byte_ready, wr_en, busy, cpu_hold, done, error} !== 6'b0 ||
            wr_addr !== 10'd0 || wr_data !== 32'd0 || word_count !== 11'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got flags=%b addr=%0d data=%h cnt=%0d want all 0",
                     {byte_ready, wr_en, busy, cpu_hold, done, error}, wr_addr, wr_data, word_count);
        end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (n_writes !== 1 || log_data[0] !== 32'hCAFEBABE) begin
            errors++;
            $display("[TB] FAIL midreset_partial got writes=%0d data=%h want 1 cafebabe", n_writes, log_data[0]);
        end
        n_writes = 0;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_csum(8'h44);
        byte_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || n_writes !== 1 || log_addr[0] !== 10'd0 || log_data[0] !== 32'h11223344) begin
            errors++;
            $display("[TB] FAIL midreset_reload got done=%b writes=%0d %0d:%h want 1 1 0:11223344", done, n_writes, log_addr[0], log_data[0]);
        end
    endtask

    task automatic test_start_while_busy();
        n_writes = 0;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        byte_valid = 1'b0;
        pulse_start();
        send_byte(8'h56, 0); send_byte(8'h78, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h09, 0);
`endif
        byte_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (n_writes !== 1 || log_data[0] !== 32'h12345678 || word_count !== 11'd1) begin
            errors++;
            $display("[TB] FAIL busy_start got writes=%0d data=%h cnt=%0d want 1 12345678 1", n_writes, log_data[0], word_count);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        checks++;
        if (error !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL csum_bad got err=%b done=%b want 1 0", error, done);
        end
        n_writes = 0;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
        send_byte(8'h08, 0);
        byte_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL csum_good got done=%b err=%b want 1 0", done, error);
        end
`else
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_start_done got done=%b err=%b want 1 0", done, error);
        end
`endif
    endtask

    task automatic test_write_spacing();
        checks++;
        if (wr_pairs !== 0) begin
            errors++;
            $display("[TB] FAIL wr_en_spacing got %0d back-to-back strobes want 0", wr_pairs);
        end
    endtask

    initial begin
        test_reset();
        test_basic(0);
        test_zero_length();
        test_oversize();
        test_basic(1);
        test_reset_mid_load();
        test_start_while_busy();
        test_write_spacing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that fills the instruction memory before the single-cycle CPU runs. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the instruction memory write port at consecutive word addresses. It holds the CPU in reset while loading and reports completion or a framing error.

## Interface
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W words (1024).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; ignored while busy.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- wr_en  out  1  one-cycle instruction memory write strobe.
- wr_addr  out  ADDR_W  word index; the CPU fetches it at byte address 4*wr_addr (IAddr[11:2]).
- wr_data  out  32  instruction word.
- busy  out  1  load in progress.
- cpu_hold  out  1  CPU reset request; equals busy.
- done  out  1  sticky; last load completed successfully.
- error  out  1  sticky; last load aborted.
- word_count  out  ADDR_W+1  words written in the current or last load.

## Operation
- Frame: LEN_HI, LEN_LO (16-bit word count N, big endian), then 4*N payload bytes, MSB first per word (first byte lands in wr_data[31:24]). With IMEM_LOADER_CHECKSUM_EN, one trailing checksum byte follows.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM (present only with the macro), FIN, ERR.
- IDLE/FIN/ERR + start -> LEN_HI. This clears done, error, word_count and the byte lane counter, and sets busy.
- A byte is accepted on a cycle with byte_valid && byte_ready. byte_ready is 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 otherwise.
- LEN_LO accept:
  - N == 0 -> FIN (or CSUM with the macro).
  - N > 2**ADDR_W -> ERR.
  - otherwise -> DATA.
- DATA: a 2-bit lane counter shifts bytes into a word register. When the 4th byte is accepted, the word is registered to wr_data/wr_addr and wr_en pulses. After the N-th word: -> FIN (or CSUM).
- wr_addr starts at 0 and increments by 1 per written word. word_count increments with each wr_en.
- FIN: busy = 0 and done = 1. ERR: busy = 0 and error = 1. Both states are held until the next start.
- start while busy is ignored. byte_valid outside accepting states is ignored and no data is consumed.

## Timing
- Reset values: byte_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, cpu_hold 0, done 0, error 0, word_count 0, state IDLE.
- start at cycle t: byte_ready = 1 at t+1.
- Write latency: the 4th byte of a word is accepted at edge t; wr_en = 1 during t+1, with wr_addr/wr_data stable in that same cycle.
- Maximum throughput is one byte per cycle, so wr_en is never high on two consecutive cycles.
- busy falls and done/error rise on the cycle after the final accepted byte. For N == 0 without the macro, this is the cycle after LEN_LO.
- Reset mid-load: everything returns to reset values immediately and any partial word is discarded. Memory contents already written are not touched.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - A running XOR is kept over all payload bytes.
  - After payload, CSUM accepts one byte.
  - If that byte equals the XOR -> FIN; otherwise -> ERR. Words already written remain in memory.
- Undefined: the CSUM state and the XOR register are absent, and the loader goes to FIN directly after the last payload byte.

## Structure
- Shared package `imem_pkg`: IMEM_ADDR_W = 10, loader state enum, and the frame header length constant (2 bytes).
- One optional sub-module, `imem_word_packer`. It covers the byte-to-word shift register, the lane counter and the word-complete strobe. The FSM, counters and checksum stay in the top module.

## Test plan
- Reset, then start; stream 00 02 24 08 00 05 AC 08 00 00 -> wr_en twice: addr 0 data 24080005, addr 1 data AC080000; done = 1, word_count = 2, cpu_hold low after.
- Length 00 00 -> no wr_en, done = 1 one cycle after LEN_LO (or after checksum byte 00 with the macro).
- Length 04 01 (1025 > 1024) -> error = 1, byte_ready = 0, no writes; new start recovers.
- byte_valid toggling 1/0 each cycle mid-word -> the same words and addresses as in a continuous stream; byte_ready never drops in DATA.
- Assert reset after 2 of 4 bytes of word 1 -> all outputs at reset values; a following start plus a full frame writes from addr 0.
- With IMEM_LOADER_CHECKSUM_EN: payload 12 34 56 78 and checksum 08 -> done; checksum 09 -> error, word at addr 0 = 12345678 already written.
